// File: rtl/dmem_bridge.sv
// dmem_bridge: turns a single-cycle memory-stage request into a registered
// valid/ready bus request, waits for the response, and reports data/error
// back to the core. The core is held in stall until the DONE state. A per-access
// timeout aborts accesses that hang on the bus.
module dmem_bridge #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        core_req,
   input  logic        core_we,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   input  logic [3:0]  core_be,
   output logic [31:0] core_rdata,
   output logic        core_stall,
   output logic        core_err,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_resp_valid,
   input  logic [31:0] bus_resp_data,
   input  logic        bus_resp_err
);

   typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t     state, state_nxt;
   logic [7:0] tmo_cnt;
   logic       tmo_hit;
   logic       illegal;
   logic       accept;
   logic       resp_take;
   logic       timeout;
   logic       addr_lo_unused;

   // The bus is word addressed; the low address bits are dropped on capture.
   assign addr_lo_unused = ^core_addr[1:0];

   assign tmo_hit   = (tmo_cnt == TMO_LAST);
   // A store that writes no bytes is rejected without touching the bus.
   assign illegal   = (state == IDLE) && core_req && core_we && (core_be == 4'b0000);
   assign accept    = (state == IDLE) && core_req && !illegal;
   assign resp_take = (state == RESP) && bus_resp_valid;
   // Only a response beats the timeout; a late bus_ready still aborts.
   assign timeout   = ((state == ADDR) || (state == RESP)) && tmo_hit && !resp_take;

   assign bus_valid  = (state == ADDR);
   assign core_stall = core_req && (state != DONE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state selection.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (illegal)     state_nxt = DONE;
            else if (accept) state_nxt = ADDR;
         end
         ADDR: begin
            if (timeout)        state_nxt = DONE;
            else if (bus_ready) state_nxt = RESP;
         end
         RESP: begin
            if (resp_take || timeout) state_nxt = DONE;
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture, timeout counter and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         bus_be     <= '0;
         tmo_cnt    <= '0;
         core_rdata <= '0;
         core_err   <= 1'b0;
      end else begin
         if (accept) begin
            bus_we    <= core_we;
            bus_addr  <= {core_addr[31:2], 2'b00};
            bus_wdata <= core_wdata;
            bus_be    <= core_be;
            tmo_cnt   <= '0;
         end else if ((state == ADDR) || (state == RESP)) begin
            tmo_cnt <= tmo_cnt + 8'd1;
         end

         if (illegal) begin
            core_err <= 1'b1;
         end else if (resp_take) begin
            core_err <= bus_resp_err;
            if (!bus_we) core_rdata <= bus_resp_data;
         end else if (timeout) begin
            core_err   <= 1'b1;
            core_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized scoreboard bench for dmem_bridge: a driver issues accesses and
// plays the bus, a reference model predicts each access outcome into a queue,
// and a monitor checks bus fields, stall length and results as they appear.
module tb_dmem_bridge;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        core_req = 1'b0, core_we = 1'b0;
   logic [31:0] core_addr = '0, core_wdata = '0;
   logic [3:0]  core_be = '0;
   logic [31:0] core_rdata;
   logic        core_stall, core_err;
   logic        bus_valid, bus_ready = 1'b0, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_resp_valid = 1'b0, bus_resp_err = 1'b0;
   logic [31:0] bus_resp_data = '0;

   always #5 clk = ~clk;

   dmem_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_be(core_be), .core_rdata(core_rdata),
      .core_stall(core_stall), .core_err(core_err),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
      .bus_resp_err(bus_resp_err)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        bus;
      int          stall;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   int          n_tests = 0, n_fail = 0;
   logic [31:0] m_rdata = '0;
   logic        m_err = 1'b0;
   logic        mon_en = 1'b0;
   logic [31:0] h_rdata = '0;
   logic        h_err = 1'b0;
   int          stall_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // Reference model: an access spends rdy+1 cycles in the address phase and
   // rsp+1 in the response phase; if that total exceeds TMO it is aborted
   // after TMO cycles. Stall covers the request cycle plus those cycles.
   task automatic predict(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int rdy, input int rsp,
                          input logic [31:0] rd, input logic re);
      exp_t e;
      e.we = we; e.addr = {addr[31:2], 2'b00}; e.wdata = wdata; e.be = be;
      if (we && be == 4'b0000) begin
         e.bus = 1'b0; e.stall = 1; e.rdata = m_rdata; e.err = 1'b1;
      end else begin
         e.bus = 1'b1;
         if (rdy + rsp + 2 <= TMO) begin
            e.stall = rdy + rsp + 3;
            e.rdata = we ? m_rdata : rd;
            e.err   = re;
         end else begin
            e.stall = TMO + 1;
            e.rdata = '0;
            e.err   = 1'b1;
         end
      end
      m_rdata = e.rdata;
      m_err   = e.err;
      exp_q.push_back(e);
   endtask

   // Driver: presents one access and plays the bus until DONE is seen.
   // Returns at posedge+1 of the DONE cycle with core_req still high.
   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int rdy, input int rsp,
                         input logic [31:0] rd, input logic re);
      int  a = 0, r = 0;
      bit  hs = 0, done = 0;
      predict(we, addr, wdata, be, rdy, rsp, rd, re);
      core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata; core_be = be;
      bus_ready = 1'b0; bus_resp_valid = 1'b0;
      for (int c = 0; c < TMO + 20 && !done; c++) begin
         @(posedge clk); #1;
         bus_resp_valid = 1'b0;
         bus_resp_data  = $urandom;
         bus_resp_err   = 1'($urandom);
         if (!core_stall) begin
            done = 1;
            bus_ready = 1'b0;
         end else if (bus_valid) begin
            a++;
            bus_ready      = (a > rdy);
            hs             = bus_ready;
            bus_resp_valid = 1'($urandom);
         end else if (hs) begin
            bus_ready = 1'b0;
            r++;
            if (r > rsp) begin
               bus_resp_valid = 1'b1; bus_resp_data = rd; bus_resp_err = re;
            end
         end else begin
            bus_resp_valid = 1'($urandom);
         end
      end
      if (!done) fail_now("done_never_reached");
   endtask

   // Idle gap after DONE: core_req drops only once the monitor has sampled DONE.
   task automatic gap(input int n);
      @(negedge clk); #1;
      core_req = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus_ready      = 1'b0;
         bus_resp_valid = 1'($urandom);
         bus_resp_data  = $urandom;
         bus_resp_err   = 1'($urandom);
      end
      bus_resp_valid = 1'b0;
   endtask

   // Monitor: checks bus fields in the address phase, and on DONE pops the
   // scoreboard to check result and stall length; outside DONE results hold.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && !rst) begin
            if (bus_valid) begin
               if (exp_q.size() == 0 || !exp_q[0].bus) fail_now("bus_valid_unexpected");
               else begin
                  check("bus_we",    32'(bus_we),    32'(exp_q[0].we));
                  check("bus_addr",  bus_addr,       exp_q[0].addr);
                  check("bus_wdata", bus_wdata,      exp_q[0].wdata);
                  check("bus_be",    32'(bus_be),    32'(exp_q[0].be));
               end
            end
            if (core_req && core_stall) stall_cnt++;
            if (core_req && !core_stall) begin
               if (exp_q.size() == 0) fail_now("done_unexpected");
               else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("done_rdata", core_rdata,       e.rdata);
                  check("done_err",   32'(core_err),    32'(e.err));
                  check("stall_len",  32'(stall_cnt),   32'(e.stall));
                  h_rdata = e.rdata;
                  h_err   = e.err;
               end
               stall_cnt = 0;
            end else begin
               check("hold_rdata", core_rdata,    h_rdata);
               check("hold_err",   32'(core_err), 32'(h_err));
            end
         end
      end
   end

   initial begin
      #2 rst = 1'b1;
      #1;
      check("rst_bus_valid",  32'(bus_valid),  32'd0);
      check("rst_bus_addr",   bus_addr,        32'd0);
      check("rst_bus_be",     32'(bus_be),     32'd0);
      check("rst_core_rdata", core_rdata,      32'd0);
      check("rst_core_err",   32'(core_err),   32'd0);
      check("rst_core_stall", 32'(core_stall), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Zero-wait load, unaligned address.
      do_txn(1'b0, 32'h0000_1003, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0);
      gap(2);
      // Waited store: ready on 3rd address cycle, response on 3rd response cycle.
      do_txn(1'b1, 32'h0000_2000, 32'h00AB_0000, 4'b0100, 2, 2, 32'h5555_5555, 1'b0);
      gap(1);
      // Store with no byte enables.
      do_txn(1'b1, 32'h0000_3000, 32'h1234_5678, 4'b0000, 0, 0, 32'h0, 1'b0);
      // Back-to-back after DONE; bus never ready -> timeout.
      do_txn(1'b0, 32'h0000_4004, 32'h0, 4'hF, 100, 0, 32'hCAFE_F00D, 1'b0);
      gap(4);
      // Bus error then a clean access.
      do_txn(1'b0, 32'h0000_5008, 32'h0, 4'hF, 1, 1, 32'h0BAD_0BAD, 1'b1);
      do_txn(1'b0, 32'h0000_500C, 32'h0, 4'hF, 0, 1, 32'h600D_600D, 1'b0);
      gap(1);
      // Response on the last allowed cycle wins; one cycle later is a timeout.
      do_txn(1'b0, 32'h0000_6000, 32'h0, 4'hF, 3, TMO - 5, 32'hA5A5_5A5A, 1'b0);
      do_txn(1'b0, 32'h0000_6004, 32'h0, 4'hF, 3, TMO - 4, 32'h1111_2222, 1'b0);
      gap(2);

      for (int i = 0; i < 150; i++) begin
         logic        we;
         logic [3:0]  be;
         int          rdy, rsp;
         we  = 1'($urandom);
         be  = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
         rdy = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 3);
         rsp = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 3);
         do_txn(we, $urandom, $urandom, be, rdy, rsp, $urandom, 1'($urandom_range(0, 5) == 0));
         if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
      end
      gap(2);

      // Reset in the response phase.
      mon_en = 1'b0;
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_7000; core_be = 4'hF;
      @(posedge clk); #1;
      check("rm_addr_valid", 32'(bus_valid), 32'd1);
      bus_ready = 1'b1;
      @(posedge clk); #1;
      bus_ready = 1'b0;
      check("rm_resp_valid", 32'(bus_valid),  32'd0);
      check("rm_resp_stall", 32'(core_stall), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rm_rst_valid",  32'(bus_valid),  32'd0);
      check("rm_rst_addr",   bus_addr,        32'd0);
      check("rm_rst_rdata",  core_rdata,      32'd0);
      check("rm_rst_err",    32'(core_err),   32'd0);
      core_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      bus_resp_valid = 1'b1; bus_resp_data = 32'h1234_5678; bus_resp_err = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus_resp_valid = 1'b0;
      check("rm_stale_rdata", core_rdata,      32'd0);
      check("rm_stale_err",   32'(core_err),   32'd0);
      check("rm_stale_valid", 32'(bus_valid),  32'd0);
      check("rm_idle_stall",  32'(core_stall), 32'd0);

      // Clean access after reset.
      m_rdata = '0; m_err = 1'b0; h_rdata = '0; h_err = 1'b0; stall_cnt = 0;
      mon_en = 1'b1;
      do_txn(1'b0, 32'h0000_8000, 32'h0, 4'hF, 1, 0, 32'h7777_8888, 1'b0);
      gap(2);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) fail_now("scoreboard_not_drained");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum bus cycles waited per access before abort (range 1..255).
REQ-002 SHALL have port clk, in, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, in, 1: asynchronous, active-high reset.
REQ-004 SHALL have port core_req, in, 1: access request from the memory stage.
REQ-005 SHALL have port core_we, in, 1: 1 = store, 0 = load.
REQ-006 SHALL have port core_addr, in, 32: byte address.
REQ-007 SHALL have port core_wdata, in, 32: lane-aligned store data.
REQ-008 SHALL have port core_be, in, 4: byte enables.
REQ-009 SHALL have port core_rdata, out, 32: raw word returned to the memory stage.
REQ-010 SHALL have port core_stall, out, 1: freezes the pipeline while an access is in progress.
REQ-011 SHALL have port core_err, out, 1: access faulted; qualified by the DONE state.
REQ-012 SHALL have port bus_valid, out, 1: request valid on the memory bus.
REQ-013 SHALL have port bus_ready, in, 1: bus accepts the request.
REQ-014 SHALL have ports bus_we (out, 1), bus_addr (out, 32), bus_wdata (out, 32) and bus_be (out, 4): the registered request fields.
REQ-015 SHALL have port bus_resp_valid, in, 1: response strobe.
REQ-016 SHALL have ports bus_resp_data (in, 32) and bus_resp_err (in, 1): response payload.

Function
REQ-017 SHALL implement a four-state FSM with states IDLE, ADDR, RESP and DONE.
REQ-018 IDLE SHALL behave as follows:
- If core_req = 1, capture we, {addr[31:2],2'b00}, wdata and be into the bus_* registers and go to ADDR.
- Exception: a store with be = 4'b0000 SHALL go directly to DONE with err = 1 and issue no bus request.
REQ-019 ADDR SHALL drive bus_valid = 1 and hold all bus_* fields stable until bus_ready = 1, then go to RESP; bus_valid SHALL be 0 in RESP.
REQ-020 RESP SHALL wait for bus_resp_valid = 1, then do the following and go to DONE:
- Capture bus_resp_data into core_rdata for loads; core_rdata stays unchanged for stores.
- Capture bus_resp_err into core_err.
REQ-021 DONE SHALL last exactly one cycle, then return to IDLE; core_rdata and core_err SHALL hold their values until the next capture.
REQ-022 core_stall SHALL equal core_req AND (state != DONE), combinationally; in DONE the pipeline advances.
REQ-023 A core_req seen in IDLE on the cycle after DONE SHALL be treated as a new access.
REQ-024 The timeout counter (8 bits) SHALL behave as follows:
- Clear on entry to ADDR.
- Increment each cycle in ADDR or RESP.
- When the count reaches TIMEOUT_CYCLES-1 without completion, go to DONE with core_err = 1, core_rdata = 0 and bus_valid = 0.
REQ-025 If bus_resp_valid and the timeout coincide, the response SHALL win.
REQ-026 bus_resp_valid SHALL be ignored outside RESP, including stale responses after a timeout.
REQ-027 If bus_ready = 1 on the first ADDR cycle and bus_resp_valid = 1 on the first RESP cycle, the access SHALL take 4 cycles: request cycle, then ADDR, RESP, DONE.
REQ-028 core_req falling while in ADDR or RESP SHALL NOT abort the bus transaction.

Reset
REQ-029 On rst = 1 the block SHALL immediately, without waiting for clk:
- Enter IDLE.
- Drive bus_valid = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, bus_be = 0.
- Drive core_rdata = 0, core_err = 0 and a timeout count of 0.
REQ-030 Reset asserted mid-access SHALL abandon the access, and no stale response SHALL be captured afterwards.

Verification
REQ-031 Zero-wait load:
- Stimulus: core_addr = 0x1003, core_we = 0, core_be = 4'hF; bus_ready and bus_resp_valid both 1 immediately; bus_resp_data = 0xDEADBEEF.
- Response: bus_addr = 0x1000; stall high for 3 cycles; in DONE core_rdata = 0xDEADBEEF, core_err = 0.
REQ-032 Waited store:
- Stimulus: core_be = 4'b0100, core_wdata = 0x00AB0000; bus_ready asserted on the 3rd ADDR cycle; response after 2 RESP cycles.
- Response: bus fields stable throughout ADDR; 7-cycle stall; core_err = 0.
REQ-033 Illegal store:
- Stimulus: core_we = 1, core_be = 0.
- Response: bus_valid never asserted; DONE on the next cycle with core_err = 1.
REQ-034 Timeout:
- Stimulus: TIMEOUT_CYCLES = 4, bus_ready held at 0.
- Response: DONE after 4 ADDR cycles with core_err = 1, core_rdata = 0; a later bus_resp_valid is ignored.
REQ-035 Bus error: bus_resp_err = 1 with the response -> core_err = 1 in DONE, and the next access starts clean with core_err = 0.
REQ-036 Reset mid-op: rst asserted in RESP -> bus_valid = 0 and state IDLE before the next edge; a response arriving after release is ignored.
